frame_sequencer: RTL
====================

Name: frame_sequencer

Overview:
- Top-level frame scheduler for the VGA drawing pipeline; runs one frame per fixed 48 Hz period.
- Each frame, it sequences a clear pass and then a draw pass through start/done handshakes with the clear and draw engines.
- Advances an animation phase once per frame and flags frames whose work overruns the period.
- Sits between the pixel engines and the top-level enable.

Parameters:
- FRAME_CYCLES, 520833: clock cycles per frame period (48 Hz at 25 MHz).
- TIMER_W, 20: frame timer width; must satisfy 2^TIMER_W > FRAME_CYCLES.
- PHASE_W, 8: animation phase width.
- PHASE_STEP, 1: phase increment per started frame.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run request, level-sensitive
- clear_done  in  1  1-cycle pulse from the clear engine
- draw_done  in  1  1-cycle pulse from the draw engine
- overrun_clr  in  1  clears the sticky overrun flag
- clear_start  out  1  1-cycle pulse that starts the clear engine
- draw_start  out  1  1-cycle pulse that starts the draw engine
- busy  out  1  high in CLEAR or DRAW
- frame_done  out  1  1-cycle pulse when the draw pass completes
- phase  out  PHASE_W  current animation phase
- overrun  out  1  sticky: a period expired before the draw pass finished

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, timer=0.
  - All outputs 0, phase=0.
- Frame timer:
  - Counts 0..FRAME_CYCLES-1, then wraps to 0.
  - tick is high for the one cycle in which the count equals FRAME_CYCLES-1.
  - Held at 0 in IDLE; runs in every other state.
- States: IDLE, CLEAR, DRAW, WAIT.
- IDLE:
  - enable=1 → CLEAR.
  - clear_start pulses in the same transition cycle (registered, visible the cycle after enable is sampled).
  - Timer starts from 0 on that cycle.
  - phase is not advanced for this first frame.
- CLEAR: clear_done → DRAW, with draw_start pulsed one cycle later (registered).
- DRAW: draw_done → frame_done pulse; then:
  - enable=0 → IDLE.
  - tick in the same cycle → CLEAR directly, phase+=PHASE_STEP, clear_start pulse, no overrun.
  - otherwise → WAIT.
- WAIT:
  - tick → CLEAR, phase+=PHASE_STEP, clear_start pulse.
  - enable=0 → IDLE immediately; timer resets.
- Overrun:
  - A tick seen in CLEAR or DRAW (and not coincident with draw_done) sets overrun=1.
  - No new frame starts and phase does not advance; the current handshake continues.
  - After draw_done the block waits in WAIT for the next tick, so the frame is skipped.
- overrun_clr clears overrun. If overrun_clr and a new overrun occur in the same cycle, set wins.
- enable=0 during CLEAR or DRAW:
  - The engines have no abort, so the handshake completes.
  - On draw_done the block goes to IDLE; frame_done still pulses.
- Handshake rules:
  - A done pulse received in a state that does not expect it is ignored.
  - start pulses are exactly 1 cycle and never overlap.
- Phase arithmetic: wraps modulo 2^PHASE_W.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0; engines are expected to share the reset.

Decomposition:
- Shared package:
  - state enumeration (IDLE/CLEAR/DRAW/WAIT).
  - FRAME_CYCLES default and the 48 Hz / 25 MHz derivation constants.
  - TIMER_W and PHASE_W defaults.
- Sub-module frame_timer:
  - Inputs: clk, reset, run.
  - Output: tick.
  - Parameters: FRAME_CYCLES, TIMER_W.
  - Behaviour: counter cleared while run=0.
- Everything else, including the FSM, phase register and overrun flag, lives in frame_sequencer.

Test Plan:
- Use FRAME_CYCLES=20 in simulation for all scenarios.
- Basic frame:
  - Stimulus: raise enable; clear_done 3 cycles after clear_start; draw_done 5 cycles after draw_start.
  - Required response: one clear_start and one draw_start pulse; frame_done follows draw_done; next clear_start exactly 20 cycles after the first; phase=1.
- Phase wrap: PHASE_W=2, run 5 frames → phase sequence 0,1,2,3,0.
- Overrun:
  - Stimulus: draw_done withheld 25 cycles after draw_start.
  - Required response: overrun=1 at first tick; no clear_start at that tick; next clear_start at cycle 40; phase advances by only 1.
- Coincident events:
  - Stimulus: draw_done on the tick cycle (count 19).
  - Required response: immediate CLEAR with clear_start; overrun stays 0. Separately, overrun_clr coincident with a new overrun → overrun=1.
- Disable mid-draw:
  - Stimulus: enable=0 during DRAW.
  - Required response: no further starts; frame_done pulses on draw_done; then IDLE with busy=0 and timer held at 0.
- Async reset:
  - Stimulus: assert reset mid-CLEAR, off a clock edge.
  - Required response: outputs 0 immediately; after release with enable=1, clear_start resumes; stray clear_done pulses while in IDLE are ignored.

Source files
------------

// File: rtl/frame_sequencer_pkg.sv
// Shared types and defaults for the frame sequencer.
// Frame period derives from a 25 MHz clock and a 48 Hz frame rate.
package frame_sequencer_pkg;

  localparam int CLK_HZ = 25_000_000;
  localparam int FRAME_HZ = 48;
  localparam int FRAME_CYCLES_DEF = CLK_HZ / FRAME_HZ;
  localparam int TIMER_W_DEF = 20;
  localparam int PHASE_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_WAIT
  } state_t;

endpackage

// File: rtl/frame_sequencer_timer.sv
// Frame period timer: free-runs while run is high, flags the last cycle.
// Cleared whenever run is low so each run starts a fresh period.
import frame_sequencer_pkg::*;

module frame_timer #(
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int TIMER_W = TIMER_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam logic [TIMER_W-1:0] LAST =
    TIMER_W'(FRAME_CYCLES - 1);

  logic [TIMER_W-1:0] count;

  // period counter, wraps after the last cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!run || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + TIMER_W'(1);
    end
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: clear pass, then draw pass, once per period.
// Tracks animation phase and a sticky overrun flag.
import frame_sequencer_pkg::*;

module frame_sequencer #(
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int TIMER_W = TIMER_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int PHASE_STEP = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear_done,
  input  logic               draw_done,
  input  logic               overrun_clr,
  output logic               clear_start,
  output logic               draw_start,
  output logic               busy,
  output logic               frame_done,
  output logic [PHASE_W-1:0] phase,
  output logic               overrun
);

  state_t state;
  state_t state_n;
  logic   cs_n;
  logic   ds_n;
  logic   fd_n;
  logic   adv;
  logic   ovr_set;
  logic   tick;
  logic   run;

  assign run  = (state != S_IDLE);
  assign busy = (state == S_CLEAR) ||
                (state == S_DRAW);

  frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES),
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk(clk),
    .reset(reset),
    .run(run),
    .tick(tick)
  );

  // state, registered start/done pulses, phase and overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      clear_start <= 1'b0;
      draw_start  <= 1'b0;
      frame_done  <= 1'b0;
      phase       <= '0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      clear_start <= cs_n;
      draw_start  <= ds_n;
      frame_done  <= fd_n;
      if (adv) begin
        phase <= phase + PHASE_W'(PHASE_STEP);
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  // next state; a tick mid-handshake skips the frame
  always_comb begin
    state_n = state;
    cs_n    = 1'b0;
    ds_n    = 1'b0;
    fd_n    = 1'b0;
    adv     = 1'b0;
    ovr_set = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) begin
          state_n = S_CLEAR;
          cs_n    = 1'b1;
        end
      end
      S_CLEAR: begin
        ovr_set = tick;
        if (clear_done) begin
          state_n = S_DRAW;
          ds_n    = 1'b1;
        end
      end
      S_DRAW: begin
        if (draw_done) begin
          fd_n = 1'b1;
          if (!enable) begin
            state_n = S_IDLE;
          end else if (tick) begin
            state_n = S_CLEAR;
            cs_n    = 1'b1;
            adv     = 1'b1;
          end else begin
            state_n = S_WAIT;
          end
        end else begin
          ovr_set = tick;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_n = S_IDLE;
        end else if (tick) begin
          state_n = S_CLEAR;
          cs_n    = 1'b1;
          adv     = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
